// File: rtl/slip_axis_dec.sv
// SLIP frame decoder: strips END/ESC framing and emits an AXI-Stream byte stream with tlast per frame.
// Optional frame/error counters are enabled by defining SLIP_AXIS_DEC_STATS_EN.
module slip_axis_dec (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_s_axis_tvalid,
  output logic        o_s_axis_tready,
  input  logic [7:0]  i_s_axis_tdata,
  output logic        o_m_axis_tvalid,
  input  logic        i_m_axis_tready,
  output logic [7:0]  o_m_axis_tdata,
  output logic        o_m_axis_tkeep,
  output logic        o_m_axis_tlast
`ifdef SLIP_AXIS_DEC_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
`endif
);

  localparam logic [7:0] C_END     = 8'hC0;
  localparam logic [7:0] C_ESC     = 8'hDB;
  localparam logic [7:0] C_ESC_END = 8'hDC;
  localparam logic [7:0] C_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_DISCARD} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_h_valid;
  logic [7:0]  r_h_data;
  logic        r_o_valid;
  logic [7:0]  r_o_data;
  logic        r_o_keep;
  logic        r_o_last;
  logic        r_in_frame;

  logic        w_accept;
  logic        w_o_load;
  logic [7:0]  w_o_data;
  logic        w_o_keep;
  logic        w_o_last;
  logic        w_h_load;
  logic        w_h_clr;
  logic [7:0]  w_h_byte;

  assign o_s_axis_tready = !r_o_valid || i_m_axis_tready;
  assign w_accept        = i_s_axis_tvalid && o_s_axis_tready;

  assign o_m_axis_tvalid = r_o_valid;
  assign o_m_axis_tdata  = r_o_data;
  assign o_m_axis_tkeep  = r_o_keep;
  assign o_m_axis_tlast  = r_o_last;

  always_comb begin
    w_state_nxt = r_state;
    w_o_load    = 1'b0;
    w_o_data    = r_h_data;
    w_o_keep    = 1'b1;
    w_o_last    = 1'b0;
    w_h_load    = 1'b0;
    w_h_clr     = 1'b0;
    w_h_byte    = i_s_axis_tdata;
    if (w_accept) begin
      case (r_state)
        S_IDLE, S_DATA: begin
          if (i_s_axis_tdata == C_END) begin
            // Empty frames produce nothing; otherwise the held byte closes the frame.
            w_o_load    = r_h_valid;
            w_o_last    = 1'b1;
            w_h_clr     = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (i_s_axis_tdata == C_ESC) begin
            w_state_nxt = S_ESC;
          end else begin
            w_o_load    = r_h_valid;
            w_h_load    = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
        S_ESC: begin
          if (i_s_axis_tdata == C_ESC_END || i_s_axis_tdata == C_ESC_ESC) begin
            w_o_load    = r_h_valid;
            w_h_load    = 1'b1;
            w_h_byte    = (i_s_axis_tdata == C_ESC_END) ? C_END : C_ESC;
            w_state_nxt = S_DATA;
          end else begin
            // Abort beat only if the downstream has seen, or will see, part of this frame.
            w_o_load    = r_h_valid || r_in_frame;
            w_o_data    = 8'h00;
            w_o_keep    = 1'b0;
            w_o_last    = 1'b1;
            w_h_clr     = 1'b1;
            w_state_nxt = (i_s_axis_tdata == C_END) ? S_IDLE : S_DISCARD;
          end
        end
        default: begin
          if (i_s_axis_tdata == C_END) w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_h_valid  <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_data   <= 8'h00;
      r_o_keep   <= 1'b0;
      r_o_last   <= 1'b0;
      r_in_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_h_load)     r_h_valid <= 1'b1;
      else if (w_h_clr) r_h_valid <= 1'b0;
      if (w_o_load) begin
        r_o_valid  <= 1'b1;
        r_o_data   <= w_o_data;
        r_o_keep   <= w_o_keep;
        r_o_last   <= w_o_last;
        r_in_frame <= !w_o_last;
      end else if (i_m_axis_tready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  // Hold data is qualified by r_h_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_h_load) r_h_data <= w_h_byte;
  end

`ifdef SLIP_AXIS_DEC_STATS_EN
  logic w_err;
  assign w_err = w_accept && (r_state == S_ESC) &&
                 (i_s_axis_tdata != C_ESC_END) && (i_s_axis_tdata != C_ESC_ESC);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_frame_cnt <= 16'h0000;
      o_err_cnt   <= 16'h0000;
    end else begin
      if (w_o_load && w_o_keep && w_o_last) o_frame_cnt <= o_frame_cnt + 16'h0001;
      if (w_err)                            o_err_cnt   <= o_err_cnt + 16'h0001;
    end
  end
`endif

endmodule
